// File: rtl/beta_quiet_detector.sv
// beta_quiet_detector
//   Rectifies the beta-band sample stream, smooths it with a leaky-integrator
//   envelope follower and qualifies a "beta quiet" flag through two-threshold
//   hysteresis with dwell-time counting. Feeds the SR ignition controller.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   clk_en          sample strobe; all state advances only when high
//   beta_in         signed Q14 beta-band sample
//   thresh_lo/hi    signed Q14 quiet / active thresholds
//   dwell_on/off    ticks of qualification before entering / leaving quiet
//   min_hold        minimum quiet duration (only with BETA_QUIET_MIN_HOLD_EN)
//   beta_envelope   registered signed Q14 envelope
//   beta_quiet      registered quiet flag
//   detector_state  0 ACTIVE, 1 PEND_QUIET, 2 QUIET, 3 PEND_ACTIVE
//
// Optional feature: define BETA_QUIET_MIN_HOLD_EN to enforce min_hold.
module beta_quiet_detector #(
  parameter int unsigned WIDTH       = 18,
  parameter int unsigned FRAC        = 14,
  parameter int unsigned ALPHA_SHIFT = 4,
  parameter int          ENV_INIT    = 1 << FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] beta_in,
  input  logic signed [WIDTH-1:0] thresh_lo,
  input  logic signed [WIDTH-1:0] thresh_hi,
  input  logic [15:0]             dwell_on,
  input  logic [15:0]             dwell_off,
  input  logic [15:0]             min_hold,
  output logic signed [WIDTH-1:0] beta_envelope,
  output logic                    beta_quiet,
  output logic [1:0]              detector_state
);

  localparam int unsigned DW1 = WIDTH + 1;
  localparam int unsigned DW2 = WIDTH + 2;
  localparam int unsigned CW  = 16;
  localparam int unsigned CW1 = CW + 1;

  localparam logic signed [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ACTIVE      = 2'd0,
    PEND_QUIET  = 2'd1,
    QUIET       = 2'd2,
    PEND_ACTIVE = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic signed [WIDTH-1:0] abs_c, env_next_c;
  logic signed [DW1-1:0]   diff_c, step_c;
  logic signed [DW2-1:0]   sum_c;
  logic              below_lo_c, above_hi_c, hold_ok_c;
  logic [CW1-1:0]    cnt_inc_c;
  logic [CW-1:0]     cnt_sat_c;
  logic              reach_on_c, reach_off_c;

  // Rectifier: the most-negative code has no positive twin, so saturate it
  always_comb begin
    abs_c = beta_in;
    if (beta_in == NEG_MIN) begin
      abs_c = POS_MAX;
    end else if (beta_in[WIDTH-1]) begin
      abs_c = -beta_in;
    end
  end

  // Leaky integrator with floor shift, clamped to the non-negative range
  always_comb begin
    diff_c = DW1'(abs_c) - DW1'(beta_envelope);
    step_c = diff_c >>> ALPHA_SHIFT;
    sum_c  = DW2'(beta_envelope) + DW2'(step_c);
    if (sum_c[DW2-1]) begin
      env_next_c = '0;
    end else if (sum_c > DW2'(POS_MAX)) begin
      env_next_c = POS_MAX;
    end else begin
      env_next_c = WIDTH'(sum_c);
    end
  end

  // Threshold tests use the envelope from before this tick's update
  assign below_lo_c  = beta_envelope < thresh_lo;
  assign above_hi_c  = beta_envelope > thresh_hi;
  assign cnt_inc_c   = {1'b0, cnt} + CW1'(1);
  assign cnt_sat_c   = (cnt == '1) ? cnt : cnt + CW'(1);
  assign reach_on_c  = cnt_inc_c >= {1'b0, dwell_on};
  assign reach_off_c = cnt_inc_c >= {1'b0, dwell_off};

  // Next-state and dwell counter
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ACTIVE: begin
        if (below_lo_c) begin
          if (dwell_on <= 16'd1) begin
            state_next = QUIET;
            cnt_next   = '0;
          end else begin
            state_next = PEND_QUIET;
            cnt_next   = CW'(1);
          end
        end
      end
      PEND_QUIET: begin
        if (!below_lo_c) begin
          state_next = ACTIVE;
          cnt_next   = '0;
        end else if (reach_on_c) begin
          state_next = QUIET;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_sat_c;
        end
      end
      QUIET: begin
        if (above_hi_c && hold_ok_c) begin
          if (dwell_off <= 16'd1) begin
            state_next = ACTIVE;
            cnt_next   = '0;
          end else begin
            state_next = PEND_ACTIVE;
            cnt_next   = CW'(1);
          end
        end
      end
      PEND_ACTIVE: begin
        if (!above_hi_c) begin
          state_next = QUIET;
          cnt_next   = '0;
        end else if (reach_off_c) begin
          state_next = ACTIVE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_sat_c;
        end
      end
      default: begin
        state_next = ACTIVE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef BETA_QUIET_MIN_HOLD_EN
  logic [CW-1:0] hold, hold_next_c;

  // Hold restarts on a fresh quiet entry; returns from PEND_ACTIVE keep it
  always_comb begin
    hold_next_c = hold;
    if (state == QUIET && hold != '1) begin
      hold_next_c = hold + CW'(1);
    end
    if (state_next == QUIET && (state == ACTIVE || state == PEND_QUIET)) begin
      hold_next_c = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (clk_en) begin
      hold <= hold_next_c;
    end
  end

  assign hold_ok_c = hold >= min_hold;
`else
  logic unused_min_hold;
  assign unused_min_hold = ^min_hold;
  assign hold_ok_c       = 1'b1;
`endif

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ACTIVE;
      cnt           <= '0;
      beta_envelope <= WIDTH'(ENV_INIT);
      beta_quiet    <= 1'b0;
    end else if (clk_en) begin
      state         <= state_next;
      cnt           <= cnt_next;
      beta_envelope <= env_next_c;
      beta_quiet    <= (state_next == QUIET) || (state_next == PEND_ACTIVE);
    end
  end

  assign detector_state = state;

endmodule

// File: tb/tb_beta_quiet_detector.sv
// tb_beta_quiet_detector
//   Directed bench for beta_quiet_detector: reset, gating, decay to quiet,
//   hysteresis, deassert, rectifier saturation, dwell abort, min hold,
//   single-tick dwell settings and asynchronous reset.
module tb_beta_quiet_detector;

  localparam int LO = 2000;
  localparam int HI = 3000;
  localparam logic [1:0] S_ACTIVE      = 2'd0;
  localparam logic [1:0] S_PEND_QUIET  = 2'd1;
  localparam logic [1:0] S_QUIET       = 2'd2;
  localparam logic [1:0] S_PEND_ACTIVE = 2'd3;
`ifdef BETA_QUIET_MIN_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               clk_en;
  logic signed [17:0] beta_in;
  logic signed [17:0] thresh_lo;
  logic signed [17:0] thresh_hi;
  logic [15:0]        dwell_on;
  logic [15:0]        dwell_off;
  logic [15:0]        min_hold;
  logic signed [17:0] beta_envelope;
  logic               beta_quiet;
  logic [1:0]         detector_state;

  int checks = 0;
  int errors = 0;
  int env_m  = 16384;
  int pre_env;

  beta_quiet_detector dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .beta_in        (beta_in),
    .thresh_lo      (thresh_lo),
    .thresh_hi      (thresh_hi),
    .dwell_on       (dwell_on),
    .dwell_off      (dwell_off),
    .min_hold       (min_hold),
    .beta_envelope  (beta_envelope),
    .beta_quiet     (beta_quiet),
    .detector_state (detector_state)
  );

  always #4 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic int rect(input int b);
    if (b == -131072) return 131071;
    return (b < 0) ? -b : b;
  endfunction

  // Envelope reference: floor division written out with explicit rounding
  function automatic int env_step(input int e, input int a);
    int d, q, r;
    d = a - e;
    if (d >= 0) q = d / 16;
    else        q = -((-d + 15) / 16);
    r = e + q;
    if (r < 0)      r = 0;
    if (r > 131071) r = 131071;
    return r;
  endfunction

  task automatic check_env(input string tag);
    checks++;
    assert (beta_envelope === 18'(env_m)) else begin
      errors++;
      $error("FAIL %s envelope: got %0d expected %0d", tag, beta_envelope, env_m);
    end
  endtask

  task automatic check_state(input logic [1:0] st, input string tag);
    logic q;
    q = (st == S_QUIET) || (st == S_PEND_ACTIVE);
    checks++;
    assert (detector_state === st) else begin
      errors++;
      $error("FAIL %s state: got %0d expected %0d", tag, detector_state, st);
    end
    checks++;
    assert (beta_quiet === q) else begin
      errors++;
      $error("FAIL %s quiet: got %0b expected %0b", tag, beta_quiet, q);
    end
  endtask

  // One strobe, then an idle cycle; outputs sampled on falling edges
  task automatic do_tick(input string tag);
    @(negedge clk) clk_en = 1'b1;
    @(negedge clk) clk_en = 1'b0;
    pre_env = env_m;
    env_m   = env_step(env_m, rect(int'(beta_in)));
    check_env(tag);
    @(negedge clk);
  endtask

  // Decay from ACTIVE until QUIET is expected; returns ticks taken
  task automatic go_quiet(input int dw, input string tag, output int n);
    int t0, lag;
    bit done;
    logic [1:0] st;
    t0 = 0; done = 1'b0; n = 0;
    lag = (dw > 1) ? dw - 1 : 0;
    for (int t = 1; t <= 400 && !done; t++) begin
      do_tick(tag);
      n = t;
      checks++;
      assert ($signed(beta_envelope) <= pre_env) else begin
        errors++;
        $error("FAIL %s monotonic: got %0d expected <= %0d", tag, beta_envelope, pre_env);
      end
      if (t0 == 0 && pre_env < LO) t0 = t;
      if (t0 == 0)            st = S_ACTIVE;
      else if (t - t0 >= lag) begin st = S_QUIET; done = 1'b1; end
      else                    st = S_PEND_QUIET;
      check_state(st, tag);
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL %s_timeout: got no quiet expected quiet within 400 ticks", tag);
    end
  endtask

  // From a fresh QUIET entry, drive until ACTIVE is expected
  task automatic go_active(input int dw, input int mh, input string tag);
    int t1, lag;
    bit done, hok;
    logic [1:0] st;
    t1 = 0; done = 1'b0;
    lag = (dw > 1) ? dw - 1 : 0;
    for (int t = 1; t <= 600 && !done; t++) begin
      do_tick(tag);
      hok = !HOLD_EN || (t - 1 >= mh);
      if (t1 == 0 && pre_env > HI && hok) t1 = t;
      if (t1 == 0)            st = S_QUIET;
      else if (t - t1 >= lag) begin st = S_ACTIVE; done = 1'b1; end
      else                    st = S_PEND_ACTIVE;
      check_state(st, tag);
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL %s_timeout: got no exit expected exit within 600 ticks", tag);
    end
  endtask

  initial begin
    int n, t0;
    bit ab;
    rst       = 1'b1;
    clk_en    = 1'b0;
    beta_in   = '0;
    thresh_lo = 18'(LO);
    thresh_hi = 18'(HI);
    dwell_on  = 16'd100;
    dwell_off = 16'd50;
    min_hold  = 16'd0;

    // Reset values, then gating with clk_en low
    repeat (3) @(negedge clk);
    check_env("reset");
    check_state(S_ACTIVE, "reset");
    rst     = 1'b0;
    beta_in = 18'sd12345;
    repeat (1000) @(negedge clk);
    check_env("gated");
    check_state(S_ACTIVE, "gated");

    // Decay to quiet with dwell_on = 100, then hold quiet to tick 160
    beta_in = '0;
    go_quiet(100, "decay", n);
    for (int t = n + 1; t <= 160; t++) begin
      do_tick("decay_hold");
      check_state(S_QUIET, "decay_hold");
    end

    // Hysteresis band: alternating +/-2500 keeps QUIET
    for (int t = 0; t < 200; t++) begin
      beta_in = (t % 2 == 0) ? 18'sd2500 : -18'sd2500;
      do_tick("hyst");
      check_state(S_QUIET, "hyst");
    end
    checks++;
    assert ($signed(beta_envelope) > LO && $signed(beta_envelope) < HI) else begin
      errors++;
      $error("FAIL hyst_band envelope: got %0d expected between %0d and %0d", beta_envelope, LO, HI);
    end

    // Mid-run gating: a large input with no strobe changes nothing
    beta_in = 18'sd30000;
    repeat (50) @(negedge clk);
    check_env("gated_run");
    check_state(S_QUIET, "gated_run");

    // Deassert with dwell_off = 50
    beta_in = 18'sd8000;
    go_active(50, 0, "deassert");

    // Most-negative input rectifies to full scale without wrapping
    beta_in = -18'sd131072;
    for (int t = 0; t < 250; t++) begin
      do_tick("rect");
      check_state(S_ACTIVE, "rect");
    end
    checks++;
    assert ($signed(beta_envelope) > 131000) else begin
      errors++;
      $error("FAIL rect_level envelope: got %0d expected > 131000", beta_envelope);
    end

    // Dwell abort: enter PEND_QUIET, then a burst pushes env back up
    beta_in = '0;
    t0 = 0;
    for (int t = 1; t <= 200 && t0 == 0; t++) begin
      do_tick("abort_in");
      if (pre_env < LO) t0 = t;
      check_state((t0 == 0) ? S_ACTIVE : S_PEND_QUIET, "abort_in");
    end
    checks++;
    assert (t0 != 0) else begin
      errors++;
      $error("FAIL abort_in_timeout: got no pend expected pend within 200 ticks");
    end
    repeat (30) begin
      do_tick("abort_pend");
      check_state(S_PEND_QUIET, "abort_pend");
    end
    beta_in = 18'sd16000;
    ab = 1'b0;
    repeat (5) begin
      do_tick("abort_burst");
      if (pre_env >= LO) ab = 1'b1;
      check_state(ab ? S_ACTIVE : S_PEND_QUIET, "abort_burst");
    end
    check_state(S_ACTIVE, "abort_done");
    beta_in = '0;
    go_quiet(100, "redwell", n);

    // Min hold: drive high right after quiet entry
    min_hold = 16'd400;
    beta_in  = 18'sd8000;
    go_active(50, 400, "min_hold");

    // Single-tick dwell settings transition directly
    min_hold = 16'd0;
    dwell_on = 16'd1;
    beta_in  = '0;
    go_quiet(1, "dwell_on1", n);
    dwell_off = 16'd0;
    beta_in   = 18'sd8000;
    go_active(0, 0, "dwell_off0");
    beta_in = '0;
    go_quiet(1, "requiet", n);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    env_m = 16384;
    check_env("async_rst");
    check_state(S_ACTIVE, "async_rst");
    @(negedge clk) rst = 1'b0;
    dwell_on = 16'd100;
    do_tick("post_rst");
    check_state(S_ACTIVE, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/beta_quiet_detector.md
Name: beta_quiet_detector

Overview:
- Upstream stage of the SR ignition controller; produces its `beta_quiet` gating input.
- Rectifies the band-limited beta-band sample stream and smooths it with a leaky-integrator envelope follower.
- Applies a two-threshold hysteresis with dwell-time qualification.
- Runs on the shared 4 kHz `clk_en` strobe (every 10 `clk` cycles in FAST_SIM).

Parameters:
- WIDTH, 18, sample/envelope width, signed fixed point.
- FRAC, 14, fractional bits (Q14: 1.0 = 16384).
- ALPHA_SHIFT, 4, envelope smoothing shift (alpha = 2^-ALPHA_SHIFT).
- ENV_INIT, 16384, envelope reset value (1.0: starts "beta active").

Ports:
- clk  in  1  system clock, 125 MHz.
- rst  in  1  reset, asynchronous, active-high.
- clk_en  in  1  sample strobe; all state advances only when high.
- beta_in  in  WIDTH  signed beta-band sample, Q14.
- thresh_lo  in  WIDTH  signed Q14 "quiet" threshold.
- thresh_hi  in  WIDTH  signed Q14 "active" threshold.
- dwell_on  in  16  ticks below thresh_lo required to assert quiet.
- dwell_off  in  16  ticks above thresh_hi required to deassert quiet.
- min_hold  in  16  minimum quiet duration in ticks (used only with the optional feature).
- beta_envelope  out  WIDTH  signed Q14 envelope, registered.
- beta_quiet  out  1  registered quiet flag to the ignition controller.
- detector_state  out  2  0 ACTIVE, 1 PEND_QUIET, 2 QUIET, 3 PEND_ACTIVE.

Behaviour:
- Reset values:
  - beta_envelope = ENV_INIT, beta_quiet = 0, detector_state = ACTIVE.
  - Dwell counter = 0, hold counter = 0.
- Gating: nothing changes on cycles with clk_en = 0.
- Latency: all outputs update on the clk edge at which clk_en is sampled high (1 clk after the strobe is presented).
- Rectify: abs = |beta_in|; the most-negative input saturates to 2^(WIDTH-1)-1.
- Envelope update:
  - env_next = env + ((abs - env) >>> ALPHA_SHIFT).
  - Difference computed in WIDTH+1 bits, arithmetic (floor) shift.
  - Result clamped to [0, 2^(WIDTH-1)-1].
- Comparisons use the registered env value from before the current tick's update.
- State machine, evaluated per tick (cnt = dwell counter, saturates at 16'hFFFF):
  - ACTIVE: if env < thresh_lo, go to PEND_QUIET with cnt = 1. If dwell_on <= 1, go straight to QUIET instead.
  - PEND_QUIET:
    - env >= thresh_lo: back to ACTIVE, cnt = 0.
    - Otherwise cnt++; when cnt+1 >= dwell_on, go to QUIET, cnt = 0.
  - QUIET: if env > thresh_hi, go to PEND_ACTIVE with cnt = 1. If dwell_off <= 1, go straight to ACTIVE instead.
  - PEND_ACTIVE:
    - env <= thresh_hi: back to QUIET, cnt = 0.
    - Otherwise cnt++; when cnt+1 >= dwell_off, go to ACTIVE, cnt = 0.
  - env between thresh_lo and thresh_hi: the state holds (hysteresis band).
- beta_quiet = 1 in QUIET and PEND_ACTIVE, 0 otherwise. It is registered alongside the state.
- Misconfiguration (thresh_lo > thresh_hi): comparisons apply exactly as written; no error flag is raised.
- Threshold/dwell inputs changed mid-operation take effect on the next tick. cnt is not reset.
- rst mid-operation returns everything to reset values immediately (asynchronous).

Optional Feature:
- Macro: BETA_QUIET_MIN_HOLD_EN.
- With the macro:
  - The hold counter clears on entry to QUIET from PEND_QUIET and increments (saturating) on each tick spent in QUIET.
  - The QUIET -> PEND_ACTIVE transition is suppressed until hold >= min_hold.
  - PEND_ACTIVE -> QUIET returns do not clear hold.
- Without the macro: min_hold is ignored and the hold counter is not synthesised. The port remains for instantiation compatibility.

Test Plan (all scenarios use WIDTH=18, ALPHA_SHIFT=4, thresh_lo=2000, thresh_hi=3000):
- Reset: outputs = ENV_INIT / 0 / ACTIVE; with clk_en held 0 for 1000 clk, nothing changes.
- Decay to quiet: beta_in = 0, dwell_on = 100.
  - env drops below 2000 at about tick 33.
  - beta_quiet = 0 at tick 120, = 1 by tick 140.
  - beta_envelope is monotonically non-increasing throughout.
- Dwell abort: in PEND_QUIET, a 5-tick burst of beta_in = 16000 pushes env >= 2000.
  - State returns to ACTIVE, beta_quiet stays 0.
  - Full dwell is required again afterwards.
- Hysteresis: from QUIET, beta_in = +/-2500 alternating sign.
  - env settles about 2500 (between thresholds); the state stays QUIET indefinitely.
- Deassert: from QUIET, beta_in = 8000, dwell_off = 50.
  - beta_quiet = 1 until about 50 ticks after env exceeds 3000, then 0 with state ACTIVE.
  - beta_in = -131072 is rectified as 131071 with no overflow.
- Min hold (macro on): min_hold = 400; drive beta_in = 8000 immediately after QUIET entry.
  - beta_quiet remains 1 for at least 400 ticks, then deasserts after dwell_off.
  - With the macro off, deassertion occurs after dwell_off only.
